// File: rtl/fir_out_collector_pkg.sv
// fir_out_pkg: register offsets and bit positions for fir_out_collector.
// Shared by the collector top and anything that talks to its AXI-lite port.
package fir_out_pkg;

  localparam int unsigned OFF_STATUS  = 'h00;
  localparam int unsigned OFF_SAMPLES = 'h04;
  localparam int unsigned OFF_FRAMES  = 'h08;
  localparam int unsigned OFF_CKSUM   = 'h0C;
  localparam int unsigned OFF_CTRL    = 'h10;

  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_DONE  = 3;

  localparam int CTRL_CLEAR = 0;

endpackage

// File: rtl/fir_out_collector_if.sv
// fir_out_collector_if: FIR-side stream in, sink-side stream out and the
// AXI-lite status port, bundled for the collector (slave) and its driver (master).
interface fir_out_collector_if #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
);

  logic                   s_tvalid;
  logic [pDATA_WIDTH-1:0] s_tdata;
  logic                   s_tlast;
  logic                   s_tready;

  logic                   m_tvalid;
  logic [pDATA_WIDTH-1:0] m_tdata;
  logic                   m_tlast;
  logic                   m_tready;

  logic                   awvalid;
  logic                   awready;
  logic [pADDR_WIDTH-1:0] awaddr;
  logic                   wvalid;
  logic                   wready;
  logic [pDATA_WIDTH-1:0] wdata;
  logic                   arvalid;
  logic                   arready;
  logic [pADDR_WIDTH-1:0] araddr;
  logic                   rvalid;
  logic                   rready;
  logic [pDATA_WIDTH-1:0] rdata;

  modport slave (
    input  s_tvalid, s_tdata, s_tlast,
    output s_tready,
    output m_tvalid, m_tdata, m_tlast,
    input  m_tready,
    input  awvalid, awaddr,
    output awready,
    input  wvalid, wdata,
    output wready,
    input  arvalid, araddr,
    output arready,
    output rvalid, rdata,
    input  rready
  );

  modport master (
    output s_tvalid, s_tdata, s_tlast,
    input  s_tready,
    input  m_tvalid, m_tdata, m_tlast,
    output m_tready,
    output awvalid, awaddr,
    input  awready,
    output wvalid, wdata,
    input  wready,
    output arvalid, araddr,
    input  arready,
    input  rvalid, rdata,
    output rready
  );

endinterface

// File: rtl/fir_out_collector_sync_fifo.sv
// sync_fifo: single-clock FIFO with one extra pointer bit to tell full from
// empty. Head word is forced to 0 while empty so idle outputs stay quiet.
module sync_fifo #(
  parameter int pWIDTH = 33,
  parameter int pDEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [pWIDTH-1:0] din,
  input  logic              pop,
  output logic [pWIDTH-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(pDEPTH);

  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [pWIDTH-1:0] mem [pDEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer advance on accepted push / pop; wraps through the extra bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty)
        rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty masks the head.
  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_out_collector.sv
// fir_out_collector: buffers FIR output samples, forwards them to the sink and
// reports counts over AXI-lite. Define FIR_OUT_CKSUM_EN to add the tdata checksum.
module fir_out_collector
  import fir_out_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 8,
  parameter int pCNT_WIDTH  = 16
) (
  input logic               axis_clk,
  input logic               axis_rst,
  fir_out_collector_if.slave bus
);

  logic                   run;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic [pDATA_WIDTH:0]   head;

  logic [pCNT_WIDTH-1:0]  sample_cnt;
  logic [pCNT_WIDTH-1:0]  frame_cnt;
  logic                   done;
  logic [pDATA_WIDTH-1:0] cksum;

  logic                   aw_held;
  logic                   w_held;
  logic [pADDR_WIDTH-1:0] awaddr_q;
  logic [pDATA_WIDTH-1:0] wdata_q;
  logic                   wr_fire;
  logic                   clear;

  logic                   hit_status;
  logic                   hit_samples;
  logic                   hit_frames;
  logic                   hit_cksum;
  logic [pDATA_WIDTH-1:0] rd_mux;
  logic                   unused_wdata;

  // Readies held low while in reset, high from the first clock after release.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) run <= 1'b0;
    else          run <= 1'b1;
  end

  assign bus.s_tready = run & ~fifo_full;
  assign push         = bus.s_tvalid & bus.s_tready;
  assign bus.m_tvalid = ~fifo_empty;
  assign pop          = bus.m_tvalid & bus.m_tready;
  assign bus.m_tdata  = head[pDATA_WIDTH-1:0];
  assign bus.m_tlast  = head[pDATA_WIDTH];

  sync_fifo #(
    .pWIDTH (pDATA_WIDTH + 1),
    .pDEPTH (pDEPTH)
  ) u_fifo (
    .clk   (axis_clk),
    .rst   (axis_rst),
    .push  (push),
    .din   ({bus.s_tlast, bus.s_tdata}),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sample/frame counters saturate; done sticks until cleared.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      sample_cnt <= '0;
      frame_cnt  <= '0;
      done       <= 1'b0;
    end else if (clear) begin
      sample_cnt <= '0;
      frame_cnt  <= '0;
      done       <= 1'b0;
    end else if (pop) begin
      if (~&sample_cnt)
        sample_cnt <= sample_cnt + pCNT_WIDTH'(1);
      if (bus.m_tlast) begin
        done <= 1'b1;
        if (~&frame_cnt)
          frame_cnt <= frame_cnt + pCNT_WIDTH'(1);
      end
    end
  end

`ifdef FIR_OUT_CKSUM_EN
  // Wrapping sum of every forwarded sample.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst)  cksum <= '0;
    else if (clear) cksum <= '0;
    else if (pop)   cksum <= cksum + bus.m_tdata;
  end
`else
  assign cksum = '0;
`endif

  // Write channels are captured independently and retired together.
  assign bus.awready = run & ~aw_held;
  assign bus.wready  = run & ~w_held;
  assign wr_fire     = aw_held & w_held;
  assign clear       = wr_fire &&
                       (awaddr_q == pADDR_WIDTH'(OFF_CTRL)) &&
                       wdata_q[CTRL_CLEAR];
  assign unused_wdata = ^wdata_q;

  // Hold AW and W until both are present, then release both readies.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
    end else if (wr_fire) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
    end else begin
      if (bus.awvalid && bus.awready) begin
        aw_held  <= 1'b1;
        awaddr_q <= bus.awaddr;
      end
      if (bus.wvalid && bus.wready) begin
        w_held  <= 1'b1;
        wdata_q <= bus.wdata;
      end
    end
  end

  assign hit_status  = (bus.araddr == pADDR_WIDTH'(OFF_STATUS));
  assign hit_samples = (bus.araddr == pADDR_WIDTH'(OFF_SAMPLES));
  assign hit_frames  = (bus.araddr == pADDR_WIDTH'(OFF_FRAMES));
  assign hit_cksum   = (bus.araddr == pADDR_WIDTH'(OFF_CKSUM));

  // Read decode; anything unmapped (including write-only CTRL) reads 0.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      hit_status: begin
        rd_mux[ST_EMPTY] = fifo_empty;
        rd_mux[ST_FULL]  = fifo_full;
        rd_mux[ST_DONE]  = done;
      end
      hit_samples: rd_mux = pDATA_WIDTH'(sample_cnt);
      hit_frames:  rd_mux = pDATA_WIDTH'(frame_cnt);
      hit_cksum:   rd_mux = cksum;
      default:     rd_mux = '0;
    endcase
  end

  assign bus.arready = run & ~bus.rvalid;

  // Registered read response, held until the master takes it.
  always_ff @(posedge axis_clk or posedge axis_rst) begin
    if (axis_rst) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
    end else if (bus.arvalid && bus.arready) begin
      bus.rvalid <= 1'b1;
      bus.rdata  <= rd_mux;
    end else if (bus.rvalid && bus.rready) begin
      bus.rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_out_collector.sv
// tb_fir_out_collector: directed vectors for fir_out_collector.
// Build with or without FIR_OUT_CKSUM_EN; CKSUM expectations follow the define.
module tb_fir_out_collector;
  import fir_out_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic axis_clk = 1'b0;
  logic axis_rst = 1'b1;

  always #5 axis_clk = ~axis_clk;

  fir_out_collector_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

  fir_out_collector #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .pDEPTH      (8),
    .pCNT_WIDTH  (16)
  ) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [31:0] exp_d;
    logic        exp_l;
  } s_vec_t;

  typedef struct {
    logic [11:0] a;
    logic [31:0] exp;
  } r_vec_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] got_d [$];
  logic        got_l [$];
  int          got_c [$];

  always @(posedge axis_clk) cyc++;

  // Sink-side monitor: inputs are stable at negedge, so a handshake seen
  // here is the one taken at the next rising edge.
  always @(negedge axis_clk) begin
    if (!axis_rst && bus.m_tvalid && bus.m_tready) begin
      got_d.push_back(bus.m_tdata);
      got_l.push_back(bus.m_tlast);
      got_c.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timeout, handshake required within bound", name);
  endtask

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_tvalid = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tlast  = 1'b0;
    bus.m_tready = 1'b0;
    bus.awvalid  = 1'b0;
    bus.awaddr   = '0;
    bus.wvalid   = 1'b0;
    bus.wdata    = '0;
    bus.arvalid  = 1'b0;
    bus.araddr   = '0;
    bus.rready   = 1'b0;
  endtask

  task automatic do_reset();
    axis_rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    axis_rst = 1'b0;
    tick();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask

  // Leaves s_tvalid high so back-to-back calls stream without gaps.
  task automatic push(logic [31:0] d, logic l);
    int k = 0;
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = d;
    bus.s_tlast  = l;
    while (!bus.s_tready && k < 100) begin
      tick();
      k++;
    end
    if (!bus.s_tready) timeout("push");
    tick();
  endtask

  task automatic wait_out(string name, int n);
    int k = 0;
    while (got_d.size() < n && k < 200) begin
      tick();
      k++;
    end
    check(name, got_d.size(), n);
  endtask

  task automatic axil_read(logic [11:0] a, output logic [31:0] d);
    int k = 0;
    d = '0;
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    while (!bus.arready && k < 20) begin
      tick();
      k++;
    end
    if (!bus.arready) timeout("arready");
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    k = 0;
    while (!bus.rvalid && k < 20) begin
      tick();
      k++;
    end
    if (!bus.rvalid) timeout("rvalid");
    d = bus.rdata;
    tick();
    bus.rready = 1'b0;
  endtask

  task automatic rd_check(string name, logic [11:0] a, logic [31:0] exp);
    logic [31:0] d;
    axil_read(a, d);
    check(name, d, exp);
  endtask

  // W is accepted 'lead' cycles before AW.
  task automatic write_w_first(logic [11:0] a, logic [31:0] d, int lead);
    int k = 0;
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    while (!bus.wready && k < 20) begin
      tick();
      k++;
    end
    if (!bus.wready) timeout("wready");
    tick();
    bus.wvalid = 1'b0;
    check("w_held_wready", bus.wready, 1'b0);
    for (int i = 1; i < lead; i++) tick();
    check("w_held_awready", bus.awready, 1'b1);
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    k = 0;
    while (!bus.awready && k < 20) begin
      tick();
      k++;
    end
    tick();
    bus.awvalid = 1'b0;
    check("both_held_awready", bus.awready, 1'b0);
    tick();
    check("post_fire_awready", bus.awready, 1'b1);
    check("post_fire_wready", bus.wready, 1'b1);
  endtask

  s_vec_t t1 [3];
  r_vec_t t1r [6];

  initial begin
    int bad;
    logic [31:0] exp_ck7;
    logic [31:0] exp_ck1;

`ifdef FIR_OUT_CKSUM_EN
    exp_ck7 = 32'd7;
    exp_ck1 = 32'd1;
`else
    exp_ck7 = 32'd0;
    exp_ck1 = 32'd0;
`endif

    t1[0] = '{32'd5,        1'b0, 32'd5,        1'b0};
    t1[1] = '{32'hFFFFFFF9, 1'b0, 32'hFFFFFFF9, 1'b0};
    t1[2] = '{32'd9,        1'b1, 32'd9,        1'b1};

    t1r[0] = '{12'h004, 32'd3};
    t1r[1] = '{12'h008, 32'd1};
    t1r[2] = '{12'h000, 32'h0000000A};
    t1r[3] = '{12'h00C, exp_ck7};
    t1r[4] = '{12'h010, 32'd0};
    t1r[5] = '{12'h014, 32'd0};

    // Reset values
    idle_inputs();
    tick();
    tick();
    check("rst_s_tready", bus.s_tready, 1'b0);
    check("rst_m_tvalid", bus.m_tvalid, 1'b0);
    check("rst_m_tdata", bus.m_tdata, 32'd0);
    check("rst_awready", bus.awready, 1'b0);
    check("rst_arready", bus.arready, 1'b0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    axis_rst = 1'b0;
    tick();
    check("run_s_tready", bus.s_tready, 1'b1);
    check("run_awready", bus.awready, 1'b1);
    check("run_wready", bus.wready, 1'b1);
    check("run_arready", bus.arready, 1'b1);
    rd_check("rst_status", 12'(OFF_STATUS), 32'h2);

    // Test 1: one short frame
    bus.m_tready = 1'b1;
    for (int i = 0; i < 3; i++) push(t1[i].d, t1[i].l);
    bus.s_tvalid = 1'b0;
    wait_out("t1_count", 3);
    for (int i = 0; i < 3 && i < got_d.size(); i++) begin
      check($sformatf("t1_data%0d", i), got_d[i], t1[i].exp_d);
      check($sformatf("t1_last%0d", i), got_l[i], t1[i].exp_l);
    end
    for (int i = 0; i < 6; i++)
      rd_check($sformatf("t1_reg_%03h", t1r[i].a), t1r[i].a, t1r[i].exp);

    // Test 2: fill with sink stalled, then drain
    do_reset();
    for (int i = 0; i < 8; i++) push(32'd100 + 32'(i), 1'b0);
    bus.s_tvalid = 1'b0;
    check("t2_full_s_tready", bus.s_tready, 1'b0);
    bus.s_tvalid = 1'b1;
    bus.s_tdata  = 32'd108;
    bus.s_tlast  = 1'b1;
    tick();
    tick();
    check("t2_full_hold", bus.s_tready, 1'b0);
    check("t2_no_pop", got_d.size(), 0);
    bus.s_tvalid = 1'b0;
    rd_check("t2_status_full", 12'(OFF_STATUS), 32'h4);
    bus.m_tready = 1'b1;
    push(32'd108, 1'b1);
    bus.s_tvalid = 1'b0;
    wait_out("t2_count", 9);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== 32'd100 + 32'(i) || got_l[i] !== (i == 8)) bad++;
    check("t2_order", bad, 0);

    // Test 3: 600-sample stream at full rate
    do_reset();
    bus.m_tready = 1'b1;
    for (int i = 0; i < 600; i++) push(32'(i) * 32'd3 + 32'd7, i == 599);
    bus.s_tvalid = 1'b0;
    wait_out("t3_count", 600);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== 32'(i) * 32'd3 + 32'd7) bad++;
    check("t3_order", bad, 0);
    if (got_c.size() == 600)
      check("t3_span", got_c[599] - got_c[0], 599);
    rd_check("t3_samples", 12'(OFF_SAMPLES), 32'd600);
    rd_check("t3_frames", 12'(OFF_FRAMES), 32'd1);

    // Test 4: clear with W ahead of AW, data left queued
    do_reset();
    bus.m_tready = 1'b1;
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    push(32'd3, 1'b1);
    bus.s_tvalid = 1'b0;
    wait_out("t4_pre_count", 3);
    bus.m_tready = 1'b0;
    rd_check("t4_pre_samples", 12'(OFF_SAMPLES), 32'd3);
    push(32'd10, 1'b0);
    push(32'd11, 1'b0);
    bus.s_tvalid = 1'b0;
    write_w_first(12'(OFF_CTRL), 32'h1, 3);
    rd_check("t4_samples", 12'(OFF_SAMPLES), 32'd0);
    rd_check("t4_frames", 12'(OFF_FRAMES), 32'd0);
    rd_check("t4_status", 12'(OFF_STATUS), 32'h0);
    bus.m_tready = 1'b1;
    wait_out("t4_post_count", 5);
    if (got_d.size() == 5) begin
      check("t4_data0", got_d[3], 32'd10);
      check("t4_data1", got_d[4], 32'd11);
    end
    rd_check("t4_post_samples", 12'(OFF_SAMPLES), 32'd2);

    // Test 5: checksum wrap
    do_reset();
    bus.m_tready = 1'b1;
    push(32'hFFFFFFFF, 1'b0);
    push(32'd2, 1'b1);
    bus.s_tvalid = 1'b0;
    wait_out("t5_count", 2);
    rd_check("t5_cksum", 12'(OFF_CKSUM), exp_ck1);

    // Test 6: reset with data queued
    do_reset();
    bus.m_tready = 1'b1;
    push(32'd20, 1'b1);
    push(32'd21, 1'b0);
    bus.s_tvalid = 1'b0;
    wait_out("t6_pre_count", 2);
    bus.m_tready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'd30 + 32'(i), 1'b0);
    bus.s_tvalid = 1'b0;
    check("t6_queued_m_tvalid", bus.m_tvalid, 1'b1);
    #2;
    axis_rst = 1'b1;
    #1;
    check("t6_rst_m_tvalid", bus.m_tvalid, 1'b0);
    check("t6_rst_m_tdata", bus.m_tdata, 32'd0);
    check("t6_rst_s_tready", bus.s_tready, 1'b0);
    check("t6_rst_awready", bus.awready, 1'b0);
    tick();
    tick();
    axis_rst = 1'b0;
    tick();
    rd_check("t6_status", 12'(OFF_STATUS), 32'h2);
    rd_check("t6_samples", 12'(OFF_SAMPLES), 32'd0);
    rd_check("t6_frames", 12'(OFF_FRAMES), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
